// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam int INST_WIDTH_DEF = 32;
  localparam int INST_BYTES_DEF = 4;

endpackage

// File: rtl/inst_buf.sv
// Single-entry fetch output slot. A flush beats a capture, and a capture beats a consume.
module inst_buf
  import fetch_pkg::*;
#(
  parameter int PC_SIZE    = 32,
  parameter int INST_WIDTH = INST_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic                  consume,
  input  logic                  flush,
  input  logic [INST_WIDTH-1:0] cap_inst,
  input  logic [PC_SIZE-1:0]    cap_pc,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_SIZE-1:0]    inst_pc
);

  logic                  valid_q, valid_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [PC_SIZE-1:0]    inst_pc_q, inst_pc_d;

  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d   = 1'b1;
      inst_d    = cap_inst;
      inst_pc_d = cap_pc;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign valid   = valid_q;
  assign inst    = inst_q;
  assign inst_pc = inst_pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: steers the external pc register, issues one imem request at a time,
// and drops responses made stale by a trap or branch redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                 PC_SIZE    = 32,
  parameter logic [PC_SIZE-1:0] BOOT_ADDR  = '0,
  parameter int                 INST_BYTES = INST_BYTES_DEF,
  parameter int                 INST_WIDTH = INST_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_SIZE-1:0]    pc_out,
  output logic [PC_SIZE-1:0]    pc_in,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_SIZE-1:0]    imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_SIZE-1:0]    inst_pc,
  input  logic                  inst_ready,
  input  logic                  redirect_valid,
  input  logic [PC_SIZE-1:0]    redirect_pc,
  input  logic                  trap_valid,
  input  logic [PC_SIZE-1:0]    trap_vector,
  output logic                  busy,
  output fetch_state_e          dbg_state
);

  // Handshake: a request transfers on a clock edge where imem_req_valid && imem_req_ready;
  // responses are single-cycle pulses that are never back-pressured.

  fetch_state_e       state_q, state_d;
  logic               kill_q, kill_d;
  logic [PC_SIZE-1:0] pend_pc_q, pend_pc_d;

  logic               redir;
  logic [PC_SIZE-1:0] tgt;
  logic               slot_free;
  logic               req_ok;
  logic               capture;

  assign redir     = trap_valid | redirect_valid;
  assign tgt       = trap_valid ? trap_vector : redirect_pc;
  assign slot_free = !inst_valid || inst_ready;

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    pend_pc_d = pend_pc_q;
    pc_in     = pc_out;
    req_ok    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      BOOT: begin
        pc_in   = redir ? tgt : BOOT_ADDR;
        state_d = REQ;
      end
      REQ: begin
        req_ok = slot_free && !redir;
        if (redir) begin
          pc_in = tgt;
        end else if (req_ok && imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = REQ;
          kill_d  = 1'b0;
          if (!kill_q && !redir) begin
            capture = 1'b1;
            pc_in   = pc_out + PC_SIZE'(INST_BYTES);
          end else begin
            pc_in = redir ? tgt : pend_pc_q;
          end
        end else if (redir) begin
          // Remember the newest target; the in-flight response is now stale.
          kill_d    = 1'b1;
          pend_pc_d = tgt;
        end
      end
      default: state_d = BOOT;
    endcase
    if (rst) begin
      pc_in   = BOOT_ADDR;
      req_ok  = 1'b0;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      kill_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign imem_req_valid = req_ok;
  assign imem_req_addr  = pc_out;
  assign busy           = (state_q == WAIT) && !rst;
  assign dbg_state      = state_q;

  inst_buf #(
    .PC_SIZE   (PC_SIZE),
    .INST_WIDTH(INST_WIDTH)
  ) u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .consume (inst_ready),
    .flush   (redir),
    .cap_inst(imem_rsp_data),
    .cap_pc  (pc_out),
    .valid   (inst_valid),
    .inst    (inst),
    .inst_pc (inst_pc)
  );

endmodule
